dram_slot_scheduler: RTL
========================

Name: dram_slot_scheduler

Overview:
- Schedules the shared DRAM between three users: Apple II CPU accesses, CAS-before-RAS refresh, and a background requester (e.g. a flash-to-DRAM loader).
- Consumes the bus-phase state counter S produced by the slot-bus synchroniser. Generates registered nRAS, nCAS0, nCAS1 and the ASel row/column mux select.
- Refresh is deferred into a bounded debt counter, so background traffic can borrow the early-phase slot without starving refresh.

Parameters:
- REF_PERIOD, 13: bus cycles per refresh owed.
- REF_MAX_DEBT, 3: debt level at which refresh is forced ahead of background.
- DEBT_W, 2: width of the debt counter; must hold REF_MAX_DEBT.

Ports:
- C7M  in  1  7 MHz clock; all logic on posedge.
- nRES  in  1  reset, asynchronous, active-low.
- S  in  3  bus-phase state: 1..7 within a bus cycle, holds 7 until resync; 0 = unsynchronised.
- cpu_req  in  1  CPU DRAM select; sampled only on S==4 edge.
- cpu_bank  in  1  CPU bank (address bit 22); 0 selects nCAS0, 1 selects nCAS1.
- bg_req  in  1  background request; level, held until bg_ack.
- bg_bank  in  1  background bank select.
- nRAS  out  1  DRAM RAS, active-low, registered.
- nCAS0  out  1  DRAM CAS bank 0, active-low, registered.
- nCAS1  out  1  DRAM CAS bank 1, active-low, registered.
- ASel  out  1  0 = row address, 1 = column address.
- bg_gnt  out  1  high while the background access owns the DRAM.
- bg_ack  out  1  one-cycle pulse when the background access completes.
- ref_debt  out  DEBT_W  refreshes currently owed.
- ref_overflow  out  1  sticky; a refresh tick arrived while debt was saturated.

Behaviour:
- Reset (async): nRAS=nCAS0=nCAS1=1, ASel=0, bg_gnt=0, bg_ack=0, ref_debt=0, ref_overflow=0, tick counter=0, slot FSM IDLE.
- "Edge Sk" means a posedge at which S==k is sampled; outputs change after that edge.

Tick counter:
- Increments on every Edge S1.
- When the count is REF_PERIOD-1, it wraps to 0 and debt is incremented.
- If debt is already REF_MAX_DEBT at that moment: debt holds and ref_overflow is set.
- A refresh start and a tick on the same edge leave debt unchanged.

Slot A (background or refresh), arbitrated at Edge S1 using pre-update debt:
- debt==REF_MAX_DEBT: REFRESH.
- else bg_req: BG.
- else debt>0: REFRESH.
- else: IDLE.

REFRESH sequence:
- Edge S1: nCAS0=nCAS1=0.
- Edge S2: nRAS=0.
- Edge S3: hold.
- Edge S4: all released high.
- Debt decrements at Edge S1.

BG sequence:
- Edge S1: bg_gnt=1, nRAS=0, ASel=0.
- Edge S2: ASel=1.
- Edge S3: CAS of bg_bank=0.
- Edge S4: release nRAS/CAS, ASel=0, bg_gnt=0, bg_ack=1 for one cycle.

Slot B (CPU):
- Edge S4: latch cpu_req and cpu_bank. cpu_req is ignored at any other edge.
- If latched, Edge S5: nRAS=0. Edge S6: ASel=1. Edge S7: CAS of cpu_bank=0.
- The next edge after that first S7 sample releases all signals and sets ASel=0, regardless of S.
- A CPU access never overlaps slot A. Minimum one-cycle RAS precharge between slots.

Boundary conditions:
- Resync mid-CPU access (Edge S1 while slot B is still active): release everything at that edge and grant nothing in that slot A. The tick still counts.
- S==0 or S held at 7: no new slots start. An active sequence completes or releases as above.
- bg_req dropped before Edge S1: no grant. Dropped after grant: the sequence completes and bg_ack still pulses.
- Only one CAS bank line is low per CPU/BG access. Both are low only during refresh.

Test Plan:
- Async reset asserted mid-stimulus -> all strobes high and ASel=0 in the same cycle; ref_debt=0, ref_overflow=0 after release.
- Idle, no requests, 13 bus cycles -> ref_debt=1 after the 13th Edge S1; next Edge S1 pulls nCAS0/nCAS1 low, Edge S2 pulls nRAS low, Edge S4 releases; ref_debt back to 0.
- cpu_req=1, cpu_bank=1 at Edge S4 -> nRAS=0 after S5, ASel=1 after S6, nCAS1=0 after S7, release on the following edge; nCAS0 stays 1 throughout.
- bg_req=1 with ref_debt=1 -> BG granted, bg_ack one cycle after Edge S4, ref_debt stays 1. Repeat with ref_debt=3 -> REFRESH first, BG granted the next bus cycle.
- bg_req held 1 for 60 bus cycles -> debt rises to 3, forced refreshes interleave, ref_overflow stays 0. Hold S at 0 for 4*13 cycles with a forced tick source -> ref_overflow=1, and it stays set.
- Resync (S jumps 7->1) on the edge right after CPU CAS asserts -> all strobes released at that edge, no slot A grant in that cycle.

Source files
------------

// File: rtl/dram_slot_scheduler.sv
// dram_slot_scheduler: shares DRAM between refresh, a background requester and the CPU,
// timing every strobe off the bus-phase counter S with refresh owed as bounded debt.
module dram_slot_scheduler #(
   parameter int REF_PERIOD   = 13,
   parameter int REF_MAX_DEBT = 3,
   parameter int DEBT_W       = 2
) (
   input  logic              C7M,
   input  logic              nRES,
   input  logic [2:0]        S,
   input  logic              cpu_req,
   input  logic              cpu_bank,
   input  logic              bg_req,
   input  logic              bg_bank,
   output logic              nRAS,
   output logic              nCAS0,
   output logic              nCAS1,
   output logic              ASel,
   output logic              bg_gnt,
   output logic              bg_ack,
   output logic [DEBT_W-1:0] ref_debt,
   output logic              ref_overflow
);
   localparam int TICK_W = $clog2(REF_PERIOD);
   typedef enum logic [2:0] {
      ST_IDLE, ST_REF, ST_BG, ST_CPU_WAIT, ST_CPU_RAS, ST_CPU_COL, ST_CPU_CAS
   } state_t;
   state_t state;
   logic [TICK_W-1:0] tick_cnt;
   logic bank;
   logic s1, tick, max_debt, start_ref, start_bg;
   assign s1 = S == 3'd1;
   assign max_debt = ref_debt == DEBT_W'(REF_MAX_DEBT);
   assign tick = s1 && tick_cnt == TICK_W'(REF_PERIOD - 1);
   // Slot A only starts from IDLE; a CPU access still live at S1 forfeits the slot.
   assign start_ref = s1 && state == ST_IDLE && (max_debt || (!bg_req && ref_debt != '0));
   assign start_bg = s1 && state == ST_IDLE && !max_debt && bg_req;
   always_ff @(posedge C7M or negedge nRES) begin
      if (!nRES) begin
         state <= ST_IDLE;
         tick_cnt <= '0;
         bank <= 1'b0;
         nRAS <= 1'b1;
         nCAS0 <= 1'b1;
         nCAS1 <= 1'b1;
         ASel <= 1'b0;
         bg_gnt <= 1'b0;
         bg_ack <= 1'b0;
         ref_debt <= '0;
         ref_overflow <= 1'b0;
      end else begin
         bg_ack <= 1'b0;
         if (s1) tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         if (tick && !start_ref) begin
            if (max_debt) ref_overflow <= 1'b1;
            else ref_debt <= ref_debt + 1'b1;
         end else if (start_ref && !tick) ref_debt <= ref_debt - 1'b1;
         if (s1) begin
            nRAS <= !start_bg;
            nCAS0 <= !start_ref;
            nCAS1 <= !start_ref;
            ASel <= 1'b0;
            bg_gnt <= start_bg;
            bank <= bg_bank;
            state <= start_ref ? ST_REF : start_bg ? ST_BG : ST_IDLE;
         end else if (state == ST_CPU_CAS) begin
            nRAS <= 1'b1;
            nCAS0 <= 1'b1;
            nCAS1 <= 1'b1;
            ASel <= 1'b0;
            state <= ST_IDLE;
         end else if (S == 3'd4 && state inside {ST_IDLE, ST_REF, ST_BG}) begin
            nRAS <= 1'b1;
            nCAS0 <= 1'b1;
            nCAS1 <= 1'b1;
            ASel <= 1'b0;
            bg_gnt <= 1'b0;
            bg_ack <= state == ST_BG;
            bank <= cpu_bank;
            state <= cpu_req ? ST_CPU_WAIT : ST_IDLE;
         end else begin
            case (state)
               ST_REF: if (S == 3'd2) nRAS <= 1'b0;
               ST_BG: begin
                  if (S == 3'd2) ASel <= 1'b1;
                  if (S == 3'd3) begin
                     nCAS0 <= bank;
                     nCAS1 <= !bank;
                  end
               end
               ST_CPU_WAIT: if (S == 3'd5) begin
                  nRAS <= 1'b0;
                  state <= ST_CPU_RAS;
               end
               ST_CPU_RAS: if (S == 3'd6) begin
                  ASel <= 1'b1;
                  state <= ST_CPU_COL;
               end
               ST_CPU_COL: if (S == 3'd7) begin
                  nCAS0 <= bank;
                  nCAS1 <= !bank;
                  state <= ST_CPU_CAS;
               end
               default: ;
            endcase
         end
      end
   end
endmodule
